mrv1_tcm_arbiter: RTL and testbench
===================================

# mrv1_tcm_arbiter

Shares one single-ported, word-wide TCM RAM between the core's instruction fetch port (imem, read-only, tagged) and data port (dmem, read/write, byte enables). Picks at most one request per cycle, gives dmem priority with a starvation guard for imem, and routes the 1-cycle-latency RAM read data back to the requester that issued it. It sits between the core's imem/dmem valid/ready interfaces and a single-port RAM macro, replacing the dual-ported TCM model in single-port builds.

## Interface
- IMEM_TAG_WIDTH_P, 4: imem request/response tag width.
- ADDR_WIDTH_P, 16: TCM byte-address width; RAM holds 2^(ADDR_WIDTH_P-2) words.
- STARVE_LIMIT_P, 4: consecutive denied imem cycles before imem is forced to win; range 1..15.

- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- imem_req_vld_i  in  1  fetch request valid.
- imem_req_rdy_o  out  1  fetch request accepted this cycle.
- imem_req_tag_i  in  IMEM_TAG_WIDTH_P  fetch tag.
- imem_req_addr_i  in  32  fetch byte address.
- imem_resp_vld_o  out  1  fetch response valid.
- imem_resp_data_o  out  32  fetch data.
- imem_resp_tag_o  out  IMEM_TAG_WIDTH_P  tag of returned fetch.
- dmem_req_vld_i  in  1  data request valid.
- dmem_req_rdy_o  out  1  data request accepted this cycle.
- dmem_req_addr_i  in  32  data byte address.
- dmem_req_w_en_i  in  1  1 = write, 0 = read.
- dmem_req_w_be_i  in  4  write byte enables.
- dmem_req_w_data_i  in  32  write data.
- dmem_resp_vld_o  out  1  data response valid (reads and writes).
- dmem_resp_err_o  out  1  address out of range; qualified by dmem_resp_vld_o.
- dmem_resp_r_data_o  out  32  read data.
- ram_en_o  out  1  RAM access strobe.
- ram_addr_o  out  ADDR_WIDTH_P-2  RAM word address.
- ram_w_en_o  out  1  RAM write.
- ram_w_be_o  out  4  RAM byte enables.
- ram_w_data_o  out  32  RAM write data.
- ram_r_data_i  in  32  RAM read data, valid cycle after ram_en_o with ram_w_en_o=0.

## Operation
- Request accepted when vld && rdy. rdy outputs are combinational from current vlds and starvation state; never more than one RAM user per cycle.
- dmem out of range: dmem_req_addr_i[31:ADDR_WIDTH_P] != 0. Such a request never touches RAM, is always accepted (dmem_req_rdy_o=1), and leaves the RAM free for imem the same cycle.
- imem addresses truncated to [ADDR_WIDTH_P-1:2]; no imem error.
- Arbitration when both want RAM: dmem wins unless starve_cnt == STARVE_LIMIT_P, then imem wins. Alone, a requester always wins.
- starve_cnt (4 bits): +1 each cycle imem_req_vld_i=1 and imem not granted, saturating at STARVE_LIMIT_P; cleared on imem grant or when imem_req_vld_i=0.
- Winner drives ram_* : imem → en=1, w_en=0, be=0; dmem → its addr/w_en/be/data. Idle → ram_en_o=0, other ram_* 0.
- Response state register, one entry: {NONE, IMEM, DMEM_RD, DMEM_WR, DMEM_ERR} for this cycle's accepted ops (imem and DMEM_ERR may coexist), plus registered imem tag.
- Next cycle: IMEM → imem_resp_vld_o=1, data=ram_r_data_i, tag=stored tag. DMEM_RD → dmem_resp_vld_o=1, data=ram_r_data_i, err=0. DMEM_WR → vld=1, data=0, err=0. DMEM_ERR → vld=1, err=1, data=0.
- Response data outputs are 0 whenever the matching vld is 0.

## Timing
- Latency: accept at cycle N → response exactly cycle N+1; no backpressure on responses; full throughput 1 RAM op/cycle.
- Reset (rst_ni=0 at clock edge): resp vlds 0, err 0, stored tag 0, starve_cnt 0; during rst_ni=0 both rdys 0 and ram_en_o 0. Reset mid-operation drops any pending response; none emitted after release.
- First request accepted in the first cycle with rst_ni=1.
- Write-then-read to same word on consecutive cycles returns new data (RAM write-first not required: read is a later cycle).

## Test plan
- Reset: hold rst_ni=0 with both vlds=1 → rdys 0, ram_en_o 0, resp vlds 0; release → first cycle dmem granted.
- dmem write 0xDEADBEEF be=0xF to 0x100, then read 0x100 → write resp vld err=0 data 0; read resp data 0xDEADBEEF one cycle after accept.
- Byte-enable write be=0x2 data 0x0000AA00 over 0x11223344 → read returns 0x1122AA44.
- Both vlds held high continuously, STARVE_LIMIT_P=4 → grants D,D,D,D,I repeating; imem responses carry issued tags in order.
- dmem read at 0x0001_0000 with imem fetch 0x40 same cycle → both accepted; next cycle dmem err=1 data 0, imem data = word 0x40.
- imem fetch tag 0x5 accepted, rst_ni=0 next cycle → no imem_resp_vld_o afterwards.

Source files
------------

// File: rtl/mrv1_tcm_arbiter_if.sv
// Core-side TCM port bundle: imem fetch (read-only, tagged) and dmem load/store request/response.
// Latency: none (wires only).
// Backpressure: requests stall on *_req_rdy; responses carry no backpressure.
// Modports: slave = arbiter side, master = core side.
interface mrv1_tcm_arbiter_if #(
   parameter int IMEM_TAG_WIDTH_P = 4
) ();
   // instruction fetch
   logic                        imem_req_vld;
   logic                        imem_req_rdy;
   logic [IMEM_TAG_WIDTH_P-1:0] imem_req_tag;
   logic [31:0]                 imem_req_addr;
   logic                        imem_resp_vld;
   logic [31:0]                 imem_resp_data;
   logic [IMEM_TAG_WIDTH_P-1:0] imem_resp_tag;
   // data access
   logic                        dmem_req_vld;
   logic                        dmem_req_rdy;
   logic [31:0]                 dmem_req_addr;
   logic                        dmem_req_w_en;
   logic [3:0]                  dmem_req_w_be;
   logic [31:0]                 dmem_req_w_data;
   logic                        dmem_resp_vld;
   logic                        dmem_resp_err;
   logic [31:0]                 dmem_resp_r_data;

   modport slave (
      input  imem_req_vld, imem_req_tag, imem_req_addr,
      output imem_req_rdy, imem_resp_vld, imem_resp_data, imem_resp_tag,
      input  dmem_req_vld, dmem_req_addr, dmem_req_w_en, dmem_req_w_be, dmem_req_w_data,
      output dmem_req_rdy, dmem_resp_vld, dmem_resp_err, dmem_resp_r_data
   );

   modport master (
      output imem_req_vld, imem_req_tag, imem_req_addr,
      input  imem_req_rdy, imem_resp_vld, imem_resp_data, imem_resp_tag,
      output dmem_req_vld, dmem_req_addr, dmem_req_w_en, dmem_req_w_be, dmem_req_w_data,
      input  dmem_req_rdy, dmem_resp_vld, dmem_resp_err, dmem_resp_r_data
   );
endinterface

// File: rtl/mrv1_tcm_arbiter.sv
// Shares one single-port TCM RAM between imem fetch and dmem access; dmem has priority, imem starvation-guarded.
// Latency: request accepted in cycle N responds in cycle N+1; one RAM op per cycle.
// Backpressure: *_req_rdy combinational from current valids and starve count; responses cannot be stalled.
// Ports: clk_i/rst_ni (sync, active-low); bus = core-side imem/dmem bundle; ram_* = single-port RAM macro.
module mrv1_tcm_arbiter #(
   parameter int IMEM_TAG_WIDTH_P = 4,
   parameter int ADDR_WIDTH_P     = 16,
   parameter int STARVE_LIMIT_P   = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   mrv1_tcm_arbiter_if.slave       bus,
   output logic                    ram_en_o,
   output logic [ADDR_WIDTH_P-3:0] ram_addr_o,
   output logic                    ram_w_en_o,
   output logic [3:0]              ram_w_be_o,
   output logic [31:0]             ram_w_data_o,
   input  logic [31:0]             ram_r_data_i
);

   localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_LIMIT_P);

   // What the dmem side owes the core next cycle; imem has its own pending flag
   // because an imem fetch and an out-of-range dmem op can be accepted together.
   typedef enum logic [1:0] {DRESP_NONE, DRESP_RD, DRESP_WR, DRESP_ERR} dresp_e;

   dresp_e                      dresp_q, dresp_d;
   logic                        imem_pend_q, imem_pend_d;
   logic [IMEM_TAG_WIDTH_P-1:0] imem_tag_q, imem_tag_d;
   logic [3:0]                  starve_cnt_q, starve_cnt_d;

   logic dmem_oor, dmem_wants_ram, starved;
   logic imem_gnt, dmem_acc, dmem_ram_gnt;
   logic unused_addr_bits;

   assign unused_addr_bits = ^{bus.imem_req_addr[31:ADDR_WIDTH_P], bus.imem_req_addr[1:0],
                               bus.dmem_req_addr[1:0]};

   // Arbitration and core-facing outputs
   always_comb begin
      dmem_oor       = |bus.dmem_req_addr[31:ADDR_WIDTH_P];
      dmem_wants_ram = bus.dmem_req_vld & ~dmem_oor;
      starved        = (starve_cnt_q == STARVE_LIMIT);

      // Out-of-range dmem never uses the RAM, so it is always taken and leaves the RAM to imem.
      bus.imem_req_rdy = rst_ni & (~dmem_wants_ram | starved);
      bus.dmem_req_rdy = rst_ni & (dmem_oor | ~(bus.imem_req_vld & starved));

      imem_gnt     = bus.imem_req_vld & bus.imem_req_rdy;
      dmem_acc     = bus.dmem_req_vld & bus.dmem_req_rdy;
      dmem_ram_gnt = dmem_acc & ~dmem_oor;

      // Responses are squashed while reset is asserted so a pending op is dropped, not emitted.
      bus.imem_resp_vld    = rst_ni & imem_pend_q;
      bus.imem_resp_data   = bus.imem_resp_vld ? ram_r_data_i : 32'h0;
      bus.imem_resp_tag    = bus.imem_resp_vld ? imem_tag_q : '0;
      bus.dmem_resp_vld    = rst_ni & (dresp_q != DRESP_NONE);
      bus.dmem_resp_err    = rst_ni & (dresp_q == DRESP_ERR);
      bus.dmem_resp_r_data = (rst_ni && dresp_q == DRESP_RD) ? ram_r_data_i : 32'h0;
   end

   // RAM port mux: grants are mutually exclusive, idle drives zeros
   always_comb begin
      ram_en_o     = 1'b0;
      ram_addr_o   = '0;
      ram_w_en_o   = 1'b0;
      ram_w_be_o   = 4'h0;
      ram_w_data_o = 32'h0;
      if (imem_gnt) begin
         ram_en_o   = 1'b1;
         ram_addr_o = bus.imem_req_addr[ADDR_WIDTH_P-1:2];
      end else if (dmem_ram_gnt) begin
         ram_en_o     = 1'b1;
         ram_addr_o   = bus.dmem_req_addr[ADDR_WIDTH_P-1:2];
         ram_w_en_o   = bus.dmem_req_w_en;
         ram_w_be_o   = bus.dmem_req_w_be;
         ram_w_data_o = bus.dmem_req_w_data;
      end
   end

   // Next-state
   always_comb begin
      starve_cnt_d = 4'h0;
      if (bus.imem_req_vld && !imem_gnt)
         starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 4'h1;

      imem_pend_d = imem_gnt;
      imem_tag_d  = imem_gnt ? bus.imem_req_tag : imem_tag_q;

      dresp_d = DRESP_NONE;
      if (dmem_acc) begin
         if (dmem_oor)               dresp_d = DRESP_ERR;
         else if (bus.dmem_req_w_en) dresp_d = DRESP_WR;
         else                        dresp_d = DRESP_RD;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         dresp_q      <= DRESP_NONE;
         imem_pend_q  <= 1'b0;
         imem_tag_q   <= '0;
         starve_cnt_q <= 4'h0;
      end else begin
         dresp_q      <= dresp_d;
         imem_pend_q  <= imem_pend_d;
         imem_tag_q   <= imem_tag_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_mrv1_tcm_arbiter.sv
// Directed bench for mrv1_tcm_arbiter with a behavioural single-port RAM and response scoreboard.
// Latency: expected responses are queued at issue and popped by the monitor one cycle later.
// Backpressure: expected rdy values are hand-computed per vector; responses are never stalled.
module tb_mrv1_tcm_arbiter;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        ram_en, ram_w_en;
   logic [13:0] ram_addr;
   logic [3:0]  ram_w_be;
   logic [31:0] ram_w_data;
   logic [31:0] ram_r_data = 32'h0;

   int total = 0;
   int bad   = 0;

   typedef struct packed { logic [3:0] tag; logic [31:0] data; } iexp_t;
   typedef struct packed { logic err; logic [31:0] data; } dexp_t;
   iexp_t iq[$];
   dexp_t dq[$];

   logic [31:0] mem [0:16383];

   always #5 clk = ~clk;

   mrv1_tcm_arbiter_if #(.IMEM_TAG_WIDTH_P(4)) bus ();

   mrv1_tcm_arbiter #(
      .IMEM_TAG_WIDTH_P(4), .ADDR_WIDTH_P(16), .STARVE_LIMIT_P(4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .bus         (bus),
      .ram_en_o    (ram_en),
      .ram_addr_o  (ram_addr),
      .ram_w_en_o  (ram_w_en),
      .ram_w_be_o  (ram_w_be),
      .ram_w_data_o(ram_w_data),
      .ram_r_data_i(ram_r_data)
   );

   // Single-port RAM, registered read, per-byte write enables
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_w_en) begin
            for (int b = 0; b < 4; b++)
               if (ram_w_be[b]) mem[ram_addr][8*b +: 8] <= ram_w_data[8*b +: 8];
         end else begin
            ram_r_data <= mem[ram_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one request cycle (caller is at a negedge), check rdys and RAM strobe, queue expectations.
   task automatic issue_now(input logic iv, input logic [3:0] tag, input logic [31:0] ia,
                            input logic dv, input logic [31:0] da, input logic dw,
                            input logic [3:0] be, input logic [31:0] wd,
                            input logic exp_ir, input logic exp_dr,
                            input logic [31:0] exp_idata, input logic [31:0] exp_ddata);
      logic d_oor;
      bus.imem_req_vld    = iv;
      bus.imem_req_tag    = tag;
      bus.imem_req_addr   = ia;
      bus.dmem_req_vld    = dv;
      bus.dmem_req_addr   = da;
      bus.dmem_req_w_en   = dw;
      bus.dmem_req_w_be   = be;
      bus.dmem_req_w_data = wd;
      d_oor = (da[31:16] != 16'h0);
      #1;
      chk("imem_rdy", 64'(bus.imem_req_rdy), 64'(exp_ir));
      chk("dmem_rdy", 64'(bus.dmem_req_rdy), 64'(exp_dr));
      chk("ram_en", 64'(ram_en), 64'((iv & exp_ir) | (dv & exp_dr & ~d_oor)));
      if (iv && exp_ir) begin
         chk("ram_addr_imem", 64'(ram_addr), 64'(ia[15:2]));
         iq.push_back('{tag: tag, data: exp_idata});
      end
      if (dv && exp_dr) begin
         if (!(iv && exp_ir) && !d_oor) chk("ram_w_en_dmem", 64'(ram_w_en), 64'(dw));
         dq.push_back('{err: d_oor, data: exp_ddata});
      end
   endtask

   task automatic issue(input logic iv, input logic [3:0] tag, input logic [31:0] ia,
                        input logic dv, input logic [31:0] da, input logic dw,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic exp_ir, input logic exp_dr,
                        input logic [31:0] exp_idata, input logic [31:0] exp_ddata);
      @(negedge clk);
      issue_now(iv, tag, ia, dv, da, dw, be, wd, exp_ir, exp_dr, exp_idata, exp_ddata);
   endtask

   // Monitor: pops and compares whenever a response is presented
   initial begin
      iexp_t ie;
      dexp_t de;
      forever begin
         @(negedge clk);
         #2;
         if (bus.imem_resp_vld) begin
            if (iq.size() == 0) chk("imem_resp_unexpected", 64'(1), 64'(0));
            else begin
               ie = iq.pop_front();
               chk("imem_resp_tag", 64'(bus.imem_resp_tag), 64'(ie.tag));
               chk("imem_resp_data", 64'(bus.imem_resp_data), 64'(ie.data));
            end
         end else begin
            chk("imem_idle_data", 64'(bus.imem_resp_data), 64'(0));
         end
         if (bus.dmem_resp_vld) begin
            if (dq.size() == 0) chk("dmem_resp_unexpected", 64'(1), 64'(0));
            else begin
               de = dq.pop_front();
               chk("dmem_resp_err", 64'(bus.dmem_resp_err), 64'(de.err));
               chk("dmem_resp_data", 64'(bus.dmem_resp_r_data), 64'(de.data));
            end
         end else begin
            chk("dmem_idle_err_data", 64'({bus.dmem_resp_err, bus.dmem_resp_r_data}), 64'(0));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ig;
      for (int i = 0; i < 16384; i++) mem[i] = {16'hC0DE, 16'(i)};

      // Reset held with both requesters asking
      rst_ni = 1'b0;
      bus.imem_req_vld = 1'b1;  bus.imem_req_tag = 4'h1;  bus.imem_req_addr = 32'h40;
      bus.dmem_req_vld = 1'b1;  bus.dmem_req_addr = 32'h100;  bus.dmem_req_w_en = 1'b1;
      bus.dmem_req_w_be = 4'hF; bus.dmem_req_w_data = 32'hDEADBEEF;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_imem_rdy", 64'(bus.imem_req_rdy), 64'(0));
      chk("rst_dmem_rdy", 64'(bus.dmem_req_rdy), 64'(0));
      chk("rst_ram_en", 64'(ram_en), 64'(0));
      chk("rst_resp_vlds", 64'({bus.imem_resp_vld, bus.dmem_resp_vld}), 64'(0));

      // First cycle out of reset: dmem wins, write 0xDEADBEEF to 0x100
      @(negedge clk);
      rst_ni = 1'b1;
      issue_now(1'b1, 4'h1, 32'h40, 1'b1, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 32'h0);
      // Read back
      issue(1'b0, 4'h0, 32'h0, 1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
      // Byte-enable merge, then write-then-read on consecutive cycles
      issue(1'b0, 4'h0, 32'h0, 1'b1, 32'h200, 1'b1, 4'hF, 32'h11223344, 1'b0, 1'b1, 32'h0, 32'h0);
      issue(1'b0, 4'h0, 32'h0, 1'b1, 32'h200, 1'b1, 4'h2, 32'h0000AA00, 1'b0, 1'b1, 32'h0, 32'h0);
      issue(1'b0, 4'h0, 32'h0, 1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h1122AA44);
      // Idle: both ready, RAM quiet
      issue(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0);

      // Contention: D,D,D,D,I repeating; imem holds each request until granted
      for (int k = 0; k < 10; k++) begin
         ig = (k == 4 || k == 9);
         issue(1'b1, (k < 5) ? 4'h6 : 4'h7, (k < 5) ? 32'h40 : 32'h44,
               1'b1, 32'h100, 1'b0, 4'h0, 32'h0, ig, !ig,
               (k < 5) ? 32'hC0DE0010 : 32'hC0DE0011, 32'hDEADBEEF);
      end

      // Out-of-range dmem alongside an imem fetch: both accepted
      issue(1'b1, 4'h3, 32'h40, 1'b1, 32'h0001_0000, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1,
            32'hC0DE0010, 32'h0);

      // Fetch accepted, then reset before its response: must be dropped
      issue(1'b1, 4'h5, 32'h48, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0);
      void'(iq.pop_back());
      @(negedge clk);
      rst_ni = 1'b0;
      bus.imem_req_vld = 1'b0;
      bus.dmem_req_vld = 1'b0;
      #3;
      chk("rst_drop_imem_vld", 64'(bus.imem_resp_vld), 64'(0));
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      chk("post_rst_imem_vld", 64'(bus.imem_resp_vld), 64'(0));
      chk("imem_queue_drained", 64'(iq.size()), 64'(0));
      chk("dmem_queue_drained", 64'(dq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
